// File: rtl/digit_serial_adder_pkg.sv
// Shared constants and state encoding for the digit-serial adder datapath.
package digit_serial_adder_pkg;

  localparam int unsigned DigitW = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/cla4_slice.sv
// 4-bit carry-lookahead slice: per-bit propagate/generate feeding one lookahead node.
module cla4_slice
  import digit_serial_adder_pkg::*;
(
  input  logic [DigitW-1:0] a_i,
  input  logic [DigitW-1:0] b_i,
  input  logic              c_i,
  output logic [DigitW-1:0] s_o,
  output logic              c3_o,
  output logic              c4_o,
  output logic              p_o,
  output logic              g_o
);

  logic [DigitW-1:0] p;
  logic [DigitW-1:0] g;
  logic [DigitW-1:0] c;

  always_comb begin
    p = a_i ^ b_i;
    g = a_i & b_i;

    c[0] = c_i;
    c[1] = g[0] | (p[0] & c_i);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_i);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_i);

    p_o  = &p;
    g_o  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    c4_o = g_o | (p_o & c_i);
    c3_o = c[3];
    s_o  = p ^ c;
  end

endmodule

// File: rtl/digit_serial_adder.sv
// Digit-serial WIDTH-bit adder: one CLA slice, one digit per RUN cycle, valid/ready on both sides.
module digit_serial_adder
  import digit_serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NDIG = WIDTH / DigitW;
  localparam int unsigned CntW = $clog2(NDIG);
  localparam logic [CntW-1:0] CntLast = CntW'(NDIG - 1);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  a_sh_q, a_sh_d;
  logic [WIDTH-1:0]  b_sh_q, b_sh_d;
  logic [WIDTH-1:0]  sum_sh_q, sum_sh_d;
  logic              carry_q, carry_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;

  logic [DigitW-1:0] slice_s;
  logic              slice_c3;
  logic              slice_c4;
  logic              slice_p;
  logic              slice_g;
  logic              unused_pg;

  cla4_slice u_slice (
    .a_i  (a_sh_q[DigitW-1:0]),
    .b_i  (b_sh_q[DigitW-1:0]),
    .c_i  (carry_q),
    .s_o  (slice_s),
    .c3_o (slice_c3),
    .c4_o (slice_c4),
    .p_o  (slice_p),
    .g_o  (slice_g)
  );

  // Group P/G are only needed when slices are chained; a single serial slice ignores them.
  assign unused_pg = slice_p ^ slice_g;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    carry_d  = carry_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;

    case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        // Digits enter at the top so the first (least significant) one ends at bit 0.
        sum_sh_d = {slice_s, sum_sh_q[WIDTH-1:DigitW]};
        a_sh_d   = {{DigitW{1'b0}}, a_sh_q[WIDTH-1:DigitW]};
        b_sh_d   = {{DigitW{1'b0}}, b_sh_q[WIDTH-1:DigitW]};
        carry_d  = slice_c4;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          sum_d   = sum_sh_d;
          cout_d  = slice_c4;
          ovf_d   = slice_c3 ^ slice_c4;
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      carry_q  <= carry_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Directed and randomised checks of digit_serial_adder at WIDTH=16.
module tb_digit_serial_adder;

  localparam int W = 16;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int n_checks;
  int n_pass;

  digit_serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Accepts one operation and waits for out_valid; lat = edges from accept to out_valid.
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                        output int lat, output logic [W-1:0] s, output logic co,
                        output logic ov);
    int guard;
    @(negedge clk);
    a = x; b = y; cin = c; in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    s = sum; co = cout; ov = ovf;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    #12;
    n_checks++;
    if ({in_ready, out_valid, sum, cout, ovf} !== {1'b1, 1'b0, 16'h0, 1'b0, 1'b0})
      $display("FAIL reset: got rdy=%b vld=%b sum=%h co=%b ov=%b, want rdy=1 vld=0 sum=0000 co=0 ov=0",
               in_ready, out_valid, sum, cout, ovf);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_vectors();
    logic [W-1:0] va [3] = '{16'h0001, 16'h7FFF, 16'h1234};
    logic [W-1:0] vb [3] = '{16'hFFFF, 16'h0001, 16'h4321};
    logic         vc [3] = '{1'b0, 1'b0, 1'b1};
    logic [W-1:0] es [3] = '{16'h0000, 16'h8000, 16'h5556};
    logic         eco[3] = '{1'b1, 1'b0, 1'b0};
    logic         eov[3] = '{1'b0, 1'b1, 1'b0};
    int lat;
    logic [W-1:0] s;
    logic co, ov;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      run_op(va[i], vb[i], vc[i], lat, s, co, ov);
      n_checks++;
      if (lat !== 4) $display("FAIL latency[%0d]: got %0d, want 4", i, lat);
      else n_pass++;
      n_checks++;
      if ({co, s, ov} !== {eco[i], es[i], eov[i]})
        $display("FAIL vector[%0d]: got sum=%h co=%b ov=%b, want sum=%h co=%b ov=%b",
                 i, s, co, ov, es[i], eco[i], eov[i]);
      else n_pass++;
    end
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int lat;
    logic [W-1:0] s;
    logic co, ov;
    out_ready = 1'b0;
    run_op(16'h8000, 16'h8000, 1'b0, lat, s, co, ov);
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({out_valid, in_ready, sum, cout, ovf} !== {1'b1, 1'b0, 16'h0000, 1'b1, 1'b1})
        $display("FAIL hold[%0d]: got vld=%b rdy=%b sum=%h co=%b ov=%b, want vld=1 rdy=0 sum=0000 co=1 ov=1",
                 i, out_valid, in_ready, sum, cout, ovf);
      else n_pass++;
      a = 16'h1111; b = 16'h2222; in_valid = (i % 2 == 0);
      @(negedge clk);
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++;
    if ({out_valid, in_ready, sum} !== {1'b0, 1'b1, 16'h0000})
      $display("FAIL handoff: got vld=%b rdy=%b sum=%h, want vld=0 rdy=1 sum=0000",
               out_valid, in_ready, sum);
    else n_pass++;
    // Nothing must have started from the ignored pulses.
    repeat (6) @(negedge clk);
    n_checks++;
    if ({out_valid, in_ready} !== 2'b01)
      $display("FAIL ignored_in: got vld=%b rdy=%b, want vld=0 rdy=1", out_valid, in_ready);
    else n_pass++;
  endtask

  task automatic test_abort();
    int lat;
    int seen;
    logic [W-1:0] s;
    logic co, ov;
    out_ready = 1'b1;
    // Leave non-zero outputs behind so the reset clear is observable.
    run_op(16'h7FFF, 16'h0001, 1'b0, lat, s, co, ov);
    @(negedge clk);
    out_ready = 1'b0;
    a = 16'h1234; b = 16'h1111; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({in_ready, out_valid, sum, cout, ovf} !== {1'b1, 1'b0, 16'h0, 1'b0, 1'b0})
      $display("FAIL abort_reset: got rdy=%b vld=%b sum=%h co=%b ov=%b, want rdy=1 vld=0 sum=0000 co=0 ov=0",
               in_ready, out_valid, sum, cout, ovf);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    n_checks++;
    if (seen !== 0) $display("FAIL abort_no_output: got %0d out_valid cycles, want 0", seen);
    else n_pass++;
    out_ready = 1'b1;
    run_op(16'hAAAA, 16'h5555, 1'b1, lat, s, co, ov);
    n_checks++;
    if ({co, s, ov, lat} !== {1'b1, 16'h0000, 1'b0, 32'd4})
      $display("FAIL after_abort: got sum=%h co=%b ov=%b lat=%0d, want sum=0000 co=1 ov=0 lat=4",
               s, co, ov, lat);
    else n_pass++;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int t;
    int first;
    int second;
    int handoff_rdy;
    first = -1; second = -1; handoff_rdy = 0;
    @(negedge clk);
    a = 16'h0F0F; b = 16'h00F1; cin = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    for (t = 0; t < 40 && second < 0; t++) begin
      if (out_valid) begin
        if (in_ready) handoff_rdy++;
        if (first < 0) first = t;
        else second = t;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    n_checks++;
    if (second - first !== 6)
      $display("FAIL throughput: got %0d cycles between results, want 6", second - first);
    else n_pass++;
    n_checks++;
    if (handoff_rdy !== 0) $display("FAIL handoff_ready: got in_ready=1 in %0d handoff cycles, want 0",
                                    handoff_rdy);
    else n_pass++;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_random();
    int lat;
    int bad_sum;
    int bad_ovf;
    int bad_lat;
    logic [W-1:0] x, y, s;
    logic c, co, ov;
    logic [W:0] full;
    logic exp_ov;
    bad_sum = 0; bad_ovf = 0; bad_lat = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      x = W'($urandom);
      y = W'($urandom);
      c = 1'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_op(x, y, c, lat, s, co, ov);
      full = {1'b0, x} + {1'b0, y} + {16'h0, c};
      exp_ov = (x[W-1] == y[W-1]) && (full[W-1] != x[W-1]);
      n_checks++;
      if ({co, s} !== full) begin
        bad_sum++;
        if (bad_sum <= 5)
          $display("FAIL rand_sum[%0d]: %h+%h+%b got {co,sum}=%h, want %h", i, x, y, c, {co, s}, full);
      end else n_pass++;
      n_checks++;
      if (ov !== exp_ov) begin
        bad_ovf++;
        if (bad_ovf <= 5) $display("FAIL rand_ovf[%0d]: %h+%h+%b got %b, want %b", i, x, y, c, ov, exp_ov);
      end else n_pass++;
      if (lat != 4) bad_lat++;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
    n_checks++;
    if (bad_lat !== 0) $display("FAIL rand_latency: got %0d ops not at 4 edges, want 0", bad_lat);
    else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass = 0;
    test_reset();
    test_vectors();
    test_backpressure();
    test_abort();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
